// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-through, write-allocate cache controller, one word per line.
// Ports:
//   clk, resetn                    clock and synchronous active-low reset
//   cpu_req_* / cpu_resp_*         CPU request (valid/ready) and one-cycle response
//   tag_* / data_*                 external tag and data RAMs, read data registered one cycle
//   mem_req_* / mem_resp_*         main memory request (valid/ready) and response
//   hit_count, miss_count          saturating lookup statistics
module dm_cache_ctrl #(
  parameter int INDEX_LEN = 8,
  parameter int TAG_LEN = 16,
  parameter int NUM_CACHE_L = 2 ** INDEX_LEN,
  parameter int DATA_LEN = 32,
  localparam int ADDR_LEN = TAG_LEN + INDEX_LEN
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cpu_req_valid,
  input  logic                 cpu_req_rw,
  input  logic [ADDR_LEN-1:0]  cpu_req_addr,
  input  logic [DATA_LEN-1:0]  cpu_req_wdata,
  output logic                 cpu_req_ready,
  output logic                 cpu_resp_valid,
  output logic [DATA_LEN-1:0]  cpu_resp_rdata,
  output logic                 tag_write,
  output logic [INDEX_LEN-1:0] tag_index,
  output logic [TAG_LEN-1:0]   tag_wdata,
  input  logic [TAG_LEN-1:0]   tag_rdata,
  output logic                 data_write,
  output logic [INDEX_LEN-1:0] data_index,
  output logic [DATA_LEN-1:0]  data_wdata,
  input  logic [DATA_LEN-1:0]  data_rdata,
  output logic                 mem_req_valid,
  output logic                 mem_req_rw,
  output logic [ADDR_LEN-1:0]  mem_req_addr,
  output logic [DATA_LEN-1:0]  mem_req_wdata,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  logic [DATA_LEN-1:0]  mem_resp_rdata,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);
  typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, MEM_REQ, MEM_WAIT, FILL, RESP} state_t;
  state_t state, next;
  logic req_rw;
  logic [ADDR_LEN-1:0] req_addr;
  logic [DATA_LEN-1:0] req_wdata;
  logic [NUM_CACHE_L-1:0] valid;
  logic [INDEX_LEN-1:0] idx;
  logic [TAG_LEN-1:0] tag;
  logic hit;
  assign idx = req_addr[INDEX_LEN-1:0];
  assign tag = req_addr[ADDR_LEN-1:INDEX_LEN];
  assign hit = valid[idx] && tag_rdata == tag;
  always_ff @(posedge clk)
    state <= !resetn ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = cpu_req_valid ? LOOKUP : IDLE;
      LOOKUP:   next = COMPARE;
      COMPARE:  next = hit && !req_rw ? RESP : MEM_REQ;
      MEM_REQ:  next = mem_req_ready ? MEM_WAIT : MEM_REQ;
      MEM_WAIT: next = mem_resp_valid ? FILL : MEM_WAIT;
      FILL:     next = RESP;
      RESP:     next = IDLE;
      default:  next = IDLE;
    endcase
  end
  // Strobes are gated by resetn so a reset landing on FILL never commits a line.
  always_comb begin
    cpu_req_ready  = state == IDLE;
    cpu_resp_valid = resetn && state == RESP;
    mem_req_valid  = resetn && state == MEM_REQ;
    tag_write      = resetn && state == FILL;
    data_write     = resetn && state == FILL;
    tag_index      = idx;
    data_index     = idx;
    tag_wdata      = tag;
    data_wdata     = req_rw ? req_wdata : cpu_resp_rdata;
    mem_req_rw     = req_rw;
    mem_req_addr   = req_addr;
    mem_req_wdata  = req_wdata;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_rw         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      cpu_resp_rdata <= '0;
      valid          <= '0;
      hit_count      <= '0;
      miss_count     <= '0;
    end else begin
      if (state == IDLE && cpu_req_valid) begin
        req_rw    <= cpu_req_rw;
        req_addr  <= cpu_req_addr;
        req_wdata <= cpu_req_wdata;
      end
      if (state == COMPARE && hit && !req_rw) cpu_resp_rdata <= data_rdata;
      if (state == MEM_WAIT && mem_resp_valid && !req_rw) cpu_resp_rdata <= mem_resp_rdata;
      if (state == FILL) valid[idx] <= 1'b1;
      if (state == COMPARE && hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (state == COMPARE && !hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: scoreboard bench for dm_cache_ctrl with tag/data RAM and main memory models.
module tb_dm_cache_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;
  logic cpu_req_valid, cpu_req_rw, cpu_req_ready, cpu_resp_valid;
  logic [23:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata, cpu_resp_rdata;
  logic tag_write, data_write;
  logic [7:0] tag_index, data_index;
  logic [15:0] tag_wdata, tag_rdata;
  logic [31:0] data_wdata, data_rdata;
  logic mem_req_valid, mem_req_rw, mem_req_ready, mem_resp_valid;
  logic [23:0] mem_req_addr;
  logic [31:0] mem_req_wdata, mem_resp_rdata;
  logic [15:0] hit_count, miss_count;

  dm_cache_ctrl dut (
    .clk(clk), .resetn(resetn),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_ready(cpu_req_ready),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .tag_write(tag_write), .tag_index(tag_index), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
    .data_write(data_write), .data_index(data_index), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct packed {logic rw; logic hit; logic [31:0] rdata; logic [15:0] hits; logic [15:0] misses;} resp_t;
  typedef struct packed {logic rw; logic [23:0] addr; logic [31:0] wdata;} mreq_t;
  typedef struct packed {logic [7:0] idx; logic [15:0] tag; logic [31:0] data;} fill_t;
  resp_t exp_q[$];
  mreq_t mem_q[$];
  fill_t fill_q[$];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, acc_cyc = 0, resp_count = 0, tw_count = 0;
  int exp_hits = 0, exp_misses = 0;
  int ready_delay = 0, resp_delay = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Registered tag/data RAMs, cleared while reset is held.
  logic [15:0] tag_mem [256];
  logic [31:0] data_mem [256];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) begin
        tag_mem[i] <= 16'h0;
        data_mem[i] <= 32'h0;
      end
    end else begin
      if (tag_write) tag_mem[tag_index] <= tag_wdata;
      if (data_write) data_mem[data_index] <= data_wdata;
    end
    tag_rdata <= tag_mem[tag_index];
    data_rdata <= data_mem[data_index];
  end

  // Main memory model: checks each request against the expected queue.
  logic [31:0] mmem [logic [23:0]];
  initial begin
    mreq_t e, r;
    logic [31:0] rd;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    mmem[24'h000010] = 32'hDEADBEEF;
    mmem[24'h000110] = 32'hCAFEF00D;
    mmem[24'h000020] = 32'h0BADC0DE;
    forever begin
      @(negedge clk);
      if (mem_req_valid) begin
        r = '{mem_req_rw, mem_req_addr, mem_req_wdata};
        check("mem_req_expected", 64'(mem_q.size() != 0), 1);
        if (mem_q.size() != 0) begin
          e = mem_q.pop_front();
          check("mem_rw", r.rw, e.rw);
          check("mem_addr", r.addr, e.addr);
          if (e.rw) check("mem_wdata", r.wdata, e.wdata);
        end
        for (int i = 0; i < ready_delay; i++) begin
          @(negedge clk);
          check("hold_valid", mem_req_valid, 1);
          check("hold_addr", mem_req_addr, r.addr);
          check("hold_busy", cpu_req_ready, 0);
        end
        if (r.rw) mmem[r.addr] = r.wdata;
        rd = mmem.exists(r.addr) ? mmem[r.addr] : 32'h0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("mem_valid_drop", mem_req_valid, 0);
        repeat (resp_delay) @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = r.rw ? 32'h0 : rd;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
      end
    end
  end

  // Monitor: line fills and CPU responses.
  always @(negedge clk) begin
    if (tag_write || data_write) begin
      fill_t f;
      tw_count++;
      check("fill_expected", 64'(fill_q.size() != 0), 1);
      if (fill_q.size() != 0) begin
        f = fill_q.pop_front();
        check("fill_strobes", {tag_write, data_write}, 2'b11);
        check("fill_tag_index", tag_index, f.idx);
        check("fill_data_index", data_index, f.idx);
        check("fill_tag", tag_wdata, f.tag);
        check("fill_data", data_wdata, f.data);
      end
    end
    if (cpu_resp_valid) begin
      resp_t x;
      resp_count++;
      check("resp_expected", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        if (!x.rw) check("resp_rdata", cpu_resp_rdata, x.rdata);
        check("hit_count", hit_count, x.hits);
        check("miss_count", miss_count, x.misses);
        if (x.hit && !x.rw) check("hit_latency", 64'(cyc + 1 - acc_cyc), 3);
      end
    end
  end

  task automatic access(input logic rw, input logic [23:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic hit);
    int target;
    if (hit) exp_hits++;
    else exp_misses++;
    exp_q.push_back('{rw, hit, rd, 16'(exp_hits), 16'(exp_misses)});
    if (rw || !hit) begin
      mem_q.push_back('{rw, a, wd});
      fill_q.push_back('{a[7:0], a[23:8], rw ? wd : rd});
    end
    target = resp_count + 1;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw = rw;
    cpu_req_addr = a;
    cpu_req_wdata = wd;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cpu_req_valid = 1'b0;
    for (int i = 0; i < 200 && resp_count < target; i++) @(negedge clk);
    check("resp_timeout", 64'(resp_count >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tw_before, rc_before;
    cpu_req_valid = 1'b0;
    cpu_req_rw = 1'b0;
    cpu_req_addr = 24'h0;
    cpu_req_wdata = 32'h0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", cpu_req_ready, 1);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    check("rst_mem_valid", mem_req_valid, 0);
    check("rst_resp_valid", cpu_resp_valid, 0);
    check("rst_tag_write", tag_write, 0);
    resetn = 1'b1;
    access(1'b0, 24'h000010, 32'h0, 32'hDEADBEEF, 1'b0);
    access(1'b0, 24'h000010, 32'h0, 32'hDEADBEEF, 1'b1);
    access(1'b1, 24'h000010, 32'h12345678, 32'h0, 1'b1);
    access(1'b0, 24'h000010, 32'h0, 32'h12345678, 1'b1);
    access(1'b0, 24'h000110, 32'h0, 32'hCAFEF00D, 1'b0);
    access(1'b0, 24'h000110, 32'h0, 32'hCAFEF00D, 1'b1);
    access(1'b0, 24'h000010, 32'h0, 32'h12345678, 1'b0);
    ready_delay = 10;
    access(1'b0, 24'h000020, 32'h0, 32'h0BADC0DE, 1'b0);
    ready_delay = 0;
    resp_delay = 3;
    access(1'b1, 24'h000330, 32'h55AA55AA, 32'h0, 1'b0);
    resp_delay = 0;
    access(1'b0, 24'h000330, 32'h0, 32'h55AA55AA, 1'b1);
    // Abort a read miss while it waits for the memory response.
    resp_delay = 6;
    mem_q.push_back('{1'b0, 24'h000210, 32'h0});
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_rw = 1'b0;
    cpu_req_addr = 24'h000210;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    for (int i = 0; i < 50 && !mem_req_valid; i++) @(negedge clk);
    for (int i = 0; i < 50 && mem_req_valid; i++) @(negedge clk);
    tw_before = tw_count;
    rc_before = resp_count;
    resetn = 1'b0;
    @(negedge clk);
    check("abort_mem_valid", mem_req_valid, 0);
    check("abort_resp_valid", cpu_resp_valid, 0);
    check("abort_tag_write", tag_write, 0);
    check("abort_ready", cpu_req_ready, 1);
    check("abort_hits", hit_count, 0);
    check("abort_misses", miss_count, 0);
    resetn = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    repeat (12) @(negedge clk);
    check("abort_no_fill", 64'(tw_count - tw_before), 0);
    check("abort_no_resp", 64'(resp_count - rc_before), 0);
    resp_delay = 0;
    access(1'b0, 24'h000010, 32'h0, 32'h12345678, 1'b0);
    access(1'b0, 24'h000210, 32'h0, 32'h0, 1'b0);
    repeat (5) @(negedge clk);
    check("mem_q_drained", 64'(mem_q.size()), 0);
    check("fill_q_drained", 64'(fill_q.size()), 0);
    check("resp_q_drained", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dm_cache_ctrl.md
DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_LEN, default INDEX_LENGTH: line index width.
REQ-002 SHALL have parameter TAG_LEN, default TAG_LENGTH: tag width.
REQ-003 SHALL have parameter NUM_CACHE_L, default NUM_CACHE_LINES: line count, equal to 2**INDEX_LEN.
REQ-004 SHALL have parameter DATA_LEN, default 32: word width; one word per line; word address = {tag, index}, ADDR_LEN = TAG_LEN+INDEX_LEN.
REQ-005 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have CPU request ports: cpu_req_valid in 1; cpu_req_rw in 1 (1 = write); cpu_req_addr in ADDR_LEN; cpu_req_wdata in DATA_LEN; cpu_req_ready out 1.
REQ-008 SHALL have CPU response ports: cpu_resp_valid out 1; cpu_resp_rdata out DATA_LEN.
REQ-009 SHALL have tag-memory ports: tag_write out 1; tag_index out INDEX_LEN; tag_wdata out TAG_LEN; tag_rdata in TAG_LEN (registered, valid one cycle after index sampled with tag_write=0).
REQ-010 SHALL have data-memory ports: data_write, data_index, data_wdata, data_rdata, with the same widths (DATA_LEN for data) and timing as the tag ports.
REQ-011 SHALL have main-memory ports: mem_req_valid out 1; mem_req_rw out 1; mem_req_addr out ADDR_LEN; mem_req_wdata out DATA_LEN; mem_req_ready in 1; mem_resp_valid in 1; mem_resp_rdata in DATA_LEN.
REQ-012 SHALL have statistics ports: hit_count out 16; miss_count out 16.

Function
REQ-013 SHALL hold an internal valid bit per line, NUM_CACHE_L bits.
REQ-014 SHALL implement the states IDLE, LOOKUP, COMPARE, MEM_REQ, MEM_WAIT, FILL and RESP.
REQ-015 IDLE SHALL drive cpu_req_ready=1, and only IDLE does so. On cpu_req_valid=1, rw, addr and wdata SHALL be registered and the FSM SHALL go to LOOKUP.
REQ-016 LOOKUP SHALL drive tag_index and data_index from the registered index with the write strobes low, then go to COMPARE.
REQ-017 COMPARE: hit = valid[index] and (tag_rdata equals the registered tag).
  - Read hit: capture data_rdata into cpu_resp_rdata, go to RESP, increment hit_count.
  - Read miss: go to MEM_REQ with mem_req_rw=0, increment miss_count.
  - Write, hit or miss: go to MEM_REQ with mem_req_rw=1 and mem_req_wdata = the registered wdata; count hit or miss accordingly.
REQ-018 MEM_REQ SHALL assert mem_req_valid with addr, rw and wdata stable until mem_req_ready=1 is sampled, then go to MEM_WAIT with mem_req_valid=0 the next cycle.
REQ-019 MEM_WAIT SHALL wait for mem_resp_valid=1 (read data or write acknowledge), then go to FILL.
  - On a read, mem_resp_rdata SHALL be captured into cpu_resp_rdata.
  - No timeout.
REQ-020 FILL SHALL pulse tag_write and data_write for one cycle at the registered index. Write data: the registered wdata on a write, the captured memory data on a read. FILL SHALL set valid[index]=1, then go to RESP (write-through, write-allocate).
REQ-021 RESP SHALL assert cpu_resp_valid for exactly one cycle, then return to IDLE.
  - Read: cpu_resp_rdata is the read word.
  - Write: cpu_resp_rdata is don't-care.
REQ-022 Latency from acceptance edge to the cpu_resp_valid cycle:
  - Read hit: exactly 3 cycles.
  - Miss or write: 3 + memory ready wait + memory response wait + 2 cycles.
REQ-023 hit_count and miss_count SHALL saturate at 0xFFFF and not wrap.
REQ-024 cpu_req_valid outside IDLE SHALL be ignored. Requests are not queued.
REQ-025 mem_resp_valid outside MEM_WAIT SHALL be ignored.
REQ-026 A request at index i SHALL be serviced completely before the next request is accepted, so back-to-back same-index accesses see updated contents.

Reset
REQ-027 With resetn=0 at a rising edge, the block SHALL go to IDLE and clear all valid bits, both counters, and all registered request fields.
REQ-028 During reset, all outputs SHALL be 0 except cpu_req_ready, which SHALL be 1 from the first cycle after reset.
REQ-029 Reset mid-operation SHALL abandon the transaction with no tag/data write and no cpu_resp_valid. mem_req_valid SHALL be 0 from the cycle after the reset edge.
REQ-030 After reset, every first access to any line SHALL miss.

Verification
REQ-031 Reset, then read 0x000010 with the memory returning 0xDEADBEEF -> the access misses; exactly one memory read to 0x000010; cpu_resp_rdata=0xDEADBEEF; miss_count=1.
REQ-032 Repeat the read of 0x000010 -> the access hits; cpu_resp_valid exactly 3 cycles after acceptance; no mem_req_valid; rdata=0xDEADBEEF; hit_count=1.
REQ-033 Write 0x12345678 to 0x000010, then read 0x000010 -> one memory write carrying 0x12345678; the read hits and returns 0x12345678.
REQ-034 Read 0x000110 (same index, different tag) after the previous scenario -> the access misses; the tag is replaced; a subsequent read of 0x000010 misses.
REQ-035 Hold mem_req_ready=0 for 10 cycles -> mem_req_valid and mem_req_addr stay stable; cpu_req_ready=0 throughout.
REQ-036 Assert resetn=0 in MEM_WAIT -> no cpu_resp_valid and no tag_write; a later read of the same address misses.
